// File: rtl/hdmi_overlay_compositor.sv
// hdmi_overlay_compositor: video timing generator with single-window overlay mux (in: pixelClock, reset_n, mode, ovlX/Y/W/H, bgColour, keyColour, ovlData/ovlValid; out: ovlReady, frameStart, underflow, DE, HSYNC, VSYNC, data)
module hdmi_overlay_compositor #(
  parameter int width = 1920,
  parameter int height = 1080,
  parameter int hFront = 88,
  parameter int hSync = 44,
  parameter int hBack = 148,
  parameter int vFront = 4,
  parameter int vSync = 5,
  parameter int vBack = 36,
  parameter bit hPolarity = 1'b1,
  parameter bit vPolarity = 1'b1,
  parameter int countWidth = 12
) (
  input  logic pixelClock,
  input  logic reset_n,
  input  logic [1:0] mode,
  input  logic [countWidth-1:0] ovlX,
  input  logic [countWidth-1:0] ovlY,
  input  logic [countWidth-1:0] ovlW,
  input  logic [countWidth-1:0] ovlH,
  input  logic [23:0] bgColour,
  input  logic [23:0] keyColour,
  input  logic [23:0] ovlData,
  input  logic ovlValid,
  output logic ovlReady,
  output logic frameStart,
  output logic underflow,
  output logic DE,
  output logic HSYNC,
  output logic VSYNC,
  output logic [23:0] data
);
  localparam int hTotal = width + hFront + hSync + hBack;
  localparam int vTotal = height + vFront + vSync + vBack;
  logic [countWidth-1:0] hCount, vCount, ovlXs, ovlYs, ovlWs, ovlHs;
  logic [1:0] modeS;
  logic [23:0] bgS, keyS, blend, pix;
  logic hEnd, vEnd, origin, active, hsOn, vsOn, inWin, take, starve;
  for (genvar c = 0; c < 3; c++)
    assign blend[c*8 +: 8] = 8'((9'(ovlData[c*8 +: 8]) + 9'(bgS[c*8 +: 8])) >> 1);
  always_comb begin
    hEnd = hCount == countWidth'(hTotal - 1);
    vEnd = vCount == countWidth'(vTotal - 1);
    origin = hCount == '0 && vCount == '0;
    active = hCount < countWidth'(width) && vCount < countWidth'(height);
    hsOn = hCount >= countWidth'(width + hFront) && hCount < countWidth'(width + hFront + hSync);
    vsOn = vCount >= countWidth'(height + vFront) && vCount < countWidth'(height + vFront + vSync);
    // one extra bit so ovlX+ovlW cannot wrap; ovlW or ovlH of 0 yields an empty range
    inWin = active
      && {1'b0, hCount} >= {1'b0, ovlXs} && {1'b0, hCount} < {1'b0, ovlXs} + {1'b0, ovlWs}
      && {1'b0, vCount} >= {1'b0, ovlYs} && {1'b0, vCount} < {1'b0, ovlYs} + {1'b0, ovlHs};
    ovlReady = reset_n && inWin && modeS != 2'd3;
    take = ovlReady && ovlValid;
    starve = ovlReady && !ovlValid;
    pix = !active ? '0
        : !take ? bgS
        : modeS == 2'd0 ? ovlData
        : modeS == 2'd1 ? (ovlData == keyS ? bgS : ovlData)
        : blend;
  end
  always_ff @(posedge pixelClock) begin
    if (!reset_n || (hEnd && vEnd)) begin
      modeS <= mode;
      ovlXs <= ovlX;
      ovlYs <= ovlY;
      ovlWs <= ovlW;
      ovlHs <= ovlH;
      bgS <= bgColour;
      keyS <= keyColour;
    end
    if (!reset_n) begin
      hCount <= '0;
      vCount <= '0;
      DE <= 1'b0;
      HSYNC <= !hPolarity;
      VSYNC <= !vPolarity;
      data <= '0;
      frameStart <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hCount <= hEnd ? '0 : hCount + countWidth'(1);
      if (hEnd) vCount <= vEnd ? '0 : vCount + countWidth'(1);
      DE <= active;
      HSYNC <= hsOn ^ !hPolarity;
      VSYNC <= vsOn ^ !vPolarity;
      data <= pix;
      frameStart <= origin;
      // cleared on the frameStart output cycle; fresh starvation at (0,0) still sets it
      underflow <= starve || (underflow && !origin);
    end
  end
endmodule

// File: tb/tb_hdmi_overlay_compositor.sv
// tb_hdmi_overlay_compositor: directed self-checking bench for the compositor in a 14x7 small mode
module tb_hdmi_overlay_compositor;
  logic pixelClock = 1'b0;
  logic reset_n;
  logic [1:0] mode;
  logic [11:0] ovlX, ovlY, ovlW, ovlH;
  logic [23:0] bgColour, keyColour, ovlData;
  logic ovlValid, ovlReady, frameStart, underflow, DE, HSYNC, VSYNC;
  logic [23:0] data;
  int total = 0, bad = 0, test = 0, seq = 0, cons = 0;
  int deCnt = 0, hsCnt = 0, vsCnt = 0, fsCnt = 0;
  logic taken;
  hdmi_overlay_compositor #(
    .width(8), .height(4), .hFront(2), .hSync(2), .hBack(2),
    .vFront(1), .vSync(1), .vBack(1), .hPolarity(1'b1), .vPolarity(1'b1), .countWidth(12)
  ) dut (
    .pixelClock(pixelClock), .reset_n(reset_n), .mode(mode),
    .ovlX(ovlX), .ovlY(ovlY), .ovlW(ovlW), .ovlH(ovlH),
    .bgColour(bgColour), .keyColour(keyColour), .ovlData(ovlData), .ovlValid(ovlValid),
    .ovlReady(ovlReady), .frameStart(frameStart), .underflow(underflow),
    .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .data(data)
  );
  always #5 pixelClock = ~pixelClock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int xStart(input int f);
    return (test == 7 || (test == 6 && f > 0)) ? 4 : 2;
  endfunction
  function automatic bit inWin(input int pos);
    int f, h, v;
    f = pos / 98;
    h = (pos % 98) % 14;
    v = (pos % 98) / 14;
    return test != 1 && v >= 1 && v <= 2 && h >= xStart(f) && h < xStart(f) + 3;
  endfunction
  function automatic logic [23:0] stream(input int s);
    case (test)
      2: return 24'hA00000 + 24'(s);
      3: return (s % 2 == 0) ? 24'hFF00FF : 24'h123456;
      4: return 24'hFF8001;
      5: return 24'hB00000 + 24'(s);
      default: return 24'h00FF00;
    endcase
  endfunction
  function automatic logic [23:0] winPix(input int k, input int f);
    case (test)
      2: return 24'hA00000 + 24'(f * 6 + k);
      3: return (k % 2 == 0) ? 24'h01FF00 : 24'h123456;
      4: return 24'h80BF00;
      5: return f > 0 ? 24'hB00000 + 24'(5 + k) : k == 0 ? 24'hB00000 : k == 1 ? 24'h102030 : 24'hB00000 + 24'(k - 1);
      6: return f == 0 ? 24'h00FF00 : 24'h007F7F;
      default: return 24'h007F7F;
    endcase
  endfunction
  task automatic drive(input int pos);
    ovlValid = !(test == 5 && pos == 17);
    ovlData = stream(seq);
  endtask
  task automatic chkReset();
    chk("rst_ctl", {DE, HSYNC, VSYNC, frameStart, underflow}, 5'b0);
    chk("rst_data", data, 24'h0);
    chk("rst_ready", ovlReady, 1'b0);
  endtask
  task automatic doReset();
    reset_n = 1'b0;
    ovlValid = 1'b0;
    repeat (2) @(posedge pixelClock);
    #1;
    chkReset();
    reset_n = 1'b1;
    seq = 0;
    cons = 0;
  endtask
  task automatic run(input int frames);
    int p, f, h, v, k;
    logic act;
    logic [23:0] expData;
    drive(0);
    taken = ovlReady && ovlValid;
    for (int n = 0; n < frames * 98; n++) begin
      @(posedge pixelClock);
      #1;
      if (taken) begin
        seq++;
        cons++;
      end
      if (test == 6 && n == 15) begin
        ovlX = 12'd4;
        mode = 2'd2;
      end
      p = n % 98;
      f = n / 98;
      h = p % 14;
      v = p / 14;
      act = h < 8 && v < 4;
      k = (v - 1) * 3 + h - xStart(f);
      expData = !act ? 24'h0 : inWin(n) ? winPix(k, f) : bgColour;
      chk("ctl", {DE, HSYNC, VSYNC, frameStart, underflow},
          {act, h == 10 || h == 11, v == 5, p == 0, test == 5 && f == 0 && p >= 17});
      chk("data", data, expData);
      deCnt += int'(DE);
      hsCnt += int'(HSYNC);
      vsCnt += int'(VSYNC);
      fsCnt += int'(frameStart);
      drive(n + 1);
      chk("ready", ovlReady, inWin(n + 1));
      taken = ovlReady && ovlValid;
    end
  endtask
  initial begin
    reset_n = 1'b0;
    ovlValid = 1'b0;
    ovlData = '0;
    ovlX = 12'd2;
    ovlY = 12'd1;
    ovlW = 12'd3;
    ovlH = 12'd2;
    keyColour = 24'hFF00FF;
    test = 1;
    mode = 2'd3;
    bgColour = 24'h123456;
    doReset();
    run(3);
    chk("de_count", deCnt, 96);
    chk("hsync_count", hsCnt, 42);
    chk("vsync_count", vsCnt, 42);
    chk("framestart_count", fsCnt, 3);
    test = 2;
    mode = 2'd0;
    bgColour = 24'h102030;
    doReset();
    run(2);
    chk("opaque_cons", cons, 12);
    test = 3;
    mode = 2'd1;
    bgColour = 24'h01FF00;
    doReset();
    run(1);
    chk("key_cons", cons, 6);
    test = 4;
    mode = 2'd2;
    doReset();
    run(1);
    chk("blend_cons", cons, 6);
    test = 5;
    mode = 2'd0;
    bgColour = 24'h102030;
    doReset();
    run(2);
    chk("starve_cons", cons, 11);
    test = 6;
    mode = 2'd0;
    ovlX = 12'd2;
    bgColour = 24'h0000FE;
    doReset();
    run(2);
    chk("shadow_cons", cons, 12);
    repeat (20) @(posedge pixelClock);
    #1;
    chk("midline_ready", ovlReady, 1'b1);
    chk("midline_de", DE, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_forces_ready", ovlReady, 1'b0);
    @(posedge pixelClock);
    #1;
    chkReset();
    test = 7;
    reset_n = 1'b1;
    cons = 0;
    run(1);
    chk("restart_cons", cons, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
